// File: rtl/freq_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// The high-time helper works at a fixed maximum width so every divisor width up to HW bits fits.
package freq_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic MODE_HALF  = 1'b0;
    localparam logic MODE_PULSE = 1'b1;
    localparam int   MIN_DIV    = 2;

    // Widest divisor supported by calc_high; the divider's WIDTH must not exceed it.
    localparam int HW = 32;

    // Number of high cycles in one output period. One extra bit keeps ceil(N/2) exact at N = 2**HW-1.
    function automatic logic [HW:0] calc_high(input logic [HW-1:0] n, input logic mode);
        logic [HW:0] n_ext;
        logic [HW:0] high;
        n_ext = {1'b0, n};
        if (mode == MODE_PULSE) begin
            high = {{HW{1'b0}}, 1'b1};
        end else begin
            high = (n_ext + {{HW{1'b0}}, 1'b1}) >> 1;
        end
        return high;
    endfunction

endpackage

// File: rtl/freq_divider_prog.sv
// Runtime-programmable integer clock divider with period-start strobe.
// Divisor and duty mode reload only at period boundaries; disabling always finishes the current period.
module freq_divider_prog
    import freq_div_pkg::*;
#(
    parameter int   WIDTH        = 16,
    parameter int   DEFAULT_DIV  = 5,
    parameter logic DEFAULT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             load_err,
    output logic [WIDTH-1:0] div_active,
    output logic             pend,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               clk_out_q, clk_out_d;
    logic               tick_q, tick_d;
    logic               load_err_q, load_err_d;
    logic [WIDTH-1:0]   div_active_q, div_active_d;
    logic               mode_q, mode_d;
    logic               pend_q, pend_d;
    logic [WIDTH-1:0]   pend_div_q, pend_div_d;
    logic               pend_mode_q, pend_mode_d;

    logic               period_start;
    logic               terminal;
    logic               load_bad;
    logic               load_ok;
    logic [HW:0]        high_w;
    logic [HW:0]        cnt_inc_w;

    always_comb begin
        terminal  = (cnt_q == div_active_q - WIDTH'(1));
        high_w    = calc_high(HW'(div_active_q), mode_q);
        cnt_inc_w = (HW + 1)'(cnt_q) + (HW + 1)'(1);
        load_bad  = div_load && (div_in < WIDTH'(MIN_DIV));
        load_ok   = div_load && !load_bad;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        period_start = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (en) begin
                    period_start = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN, DRAIN: begin
                if (terminal && state_q == DRAIN && !en) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                end else begin
                    state_d = en ? RUN : DRAIN;
                    if (terminal) begin
                        period_start = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + WIDTH'(1);
                        clk_out_d = (cnt_inc_w < high_w);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase

        if (period_start) begin
            cnt_d     = '0;
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
        end
    end

    // A load arriving on the boundary edge itself must wait a full period, so
    // the boundary consumes the old pending value before the new one is captured.
    always_comb begin
        div_active_d = div_active_q;
        mode_d       = mode_q;
        pend_d       = pend_q;
        pend_div_d   = pend_div_q;
        pend_mode_d  = pend_mode_q;
        load_err_d   = load_bad;

        if (period_start && pend_q) begin
            div_active_d = pend_div_q;
            mode_d       = pend_mode_q;
            pend_d       = 1'b0;
        end
        if (load_ok) begin
            pend_div_d  = div_in;
            pend_mode_d = mode_in;
            pend_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            load_err_q   <= 1'b0;
            div_active_q <= WIDTH'(DEFAULT_DIV);
            mode_q       <= DEFAULT_MODE;
            pend_q       <= 1'b0;
            pend_div_q   <= '0;
            pend_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            load_err_q   <= load_err_d;
            div_active_q <= div_active_d;
            mode_q       <= mode_d;
            pend_q       <= pend_d;
            pend_div_q   <= pend_div_d;
            pend_mode_q  <= pend_mode_d;
        end
    end

    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign load_err   = load_err_q;
    assign div_active = div_active_q;
    assign pend       = pend_q;
    assign busy       = (state_q != IDLE);

endmodule
